// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-fed word serializer: FSM state encoding,
// default geometry and a counter-width helper.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      WAIT  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_TIMEOUT    = 15;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register with a remaining-bit counter;
// bit 0 is the current output bit and last flags the final bit of the frame.
module piso_shreg #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [CNT_W-1:0] load_count,
   input  logic             shift_en,
   output logic             bit_out,
   output logic             last
);

   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bits_left;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         bits_left <= '0;
      end else if (load) begin
         shreg     <= load_data;
         bits_left <= load_count;
      end else if (shift_en && (bits_left != '0)) begin
         shreg     <= shreg >> 1;
         bits_left <= bits_left - CNT_W'(1);
      end
   end

   assign bit_out = shreg[0];
   assign last    = (bits_left == CNT_W'(1));

endmodule

// File: rtl/word_serializer.sv
// Pops words from an upstream FIFO and sends them LSB first on a valid/ready
// serial port. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module word_serializer
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  pop,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_valid,
   output logic                  sout,
   output logic                  sout_valid,
   input  logic                  sout_ready,
   output logic                  sout_last,
   output logic                  timeout_err
);

`ifdef SERIALIZER_PARITY_EN
   localparam int unsigned FRAME_BITS = DATA_WIDTH + 1;
`else
   localparam int unsigned FRAME_BITS = DATA_WIDTH;
`endif
   localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 2);
   localparam int unsigned WCNT_W = cnt_width(TIMEOUT);

   state_t                state, state_n;
   logic [WCNT_W-1:0]     wait_cnt;
   logic                  wait_clr, wait_inc, wait_hit, err_set;
   logic                  load, shift_en, sh_bit, sh_last;
   logic [FRAME_BITS-1:0] load_word;

`ifdef SERIALIZER_PARITY_EN
   assign load_word = {^fifo_data, fifo_data};
`else
   assign load_word = fifo_data;
`endif

   // True in the WAIT cycle whose increment brings the counter to TIMEOUT.
   assign wait_hit = (32'(wait_cnt) + 32'd1) >= TIMEOUT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (wait_clr) begin
         wait_cnt <= '0;
      end else if (wait_inc && (wait_cnt != WCNT_W'(TIMEOUT))) begin
         wait_cnt <= wait_cnt + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_err <= 1'b0;
      end else if (err_set) begin
         timeout_err <= 1'b1;
      end
   end

   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      wait_clr = 1'b0;
      wait_inc = 1'b0;
      err_set  = 1'b0;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_n = POP;
         end
         POP: begin
            // FIFO drained since IDLE saw it non-empty: skip the read.
            if (fifo_empty) begin
               state_n = IDLE;
            end else begin
               pop      = 1'b1;
               wait_clr = 1'b1;
               state_n  = WAIT;
            end
         end
         WAIT: begin
            if (fifo_valid) begin
               load    = 1'b1;
               state_n = SHIFT;
            end else begin
               wait_inc = 1'b1;
               if (wait_hit) begin
                  err_set = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         SHIFT: begin
            if (sout_ready) begin
               shift_en = 1'b1;
               if (sh_last) state_n = fifo_empty ? IDLE : POP;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign sout_valid = (state == SHIFT);
   assign sout       = sout_valid & sh_bit;
   assign sout_last  = sout_valid & sh_last;

   piso_shreg #(
      .WIDTH (FRAME_BITS),
      .CNT_W (BCNT_W)
   ) u_piso (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_word),
      .load_count (BCNT_W'(FRAME_BITS)),
      .shift_en   (shift_en),
      .bit_out    (sh_bit),
      .last       (sh_last)
   );

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (DATA_WIDTH=8, TIMEOUT=15) with a
// queue-based FIFO model, a serial sink recorder and a bit-stream reference.
module tb_word_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic       pop;
   logic [7:0] fifo_data = '0;
   logic       fifo_valid = 1'b0;
   logic       sout, sout_valid, sout_last, timeout_err;
   logic       sout_ready = 1'b1;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;

   // FIFO model state
   logic [7:0] fifo_q[$];
   int         resp_delay_max = 0;
   bit         no_respond = 0;
   int         pend_delay = -1;
   logic [7:0] pend_word;
   bit         pop_seen;
   int         pop_cnt = 0;
   int         pop_viol = 0;
   int         pop_cyc_q[$];
   int         empty_fall_cyc = -1;
   bit         prev_empty = 1;

   // Sink recorder state
   logic rx_bits[$];
   logic rx_last[$];
   int   rx_cyc[$];
   int   first_valid_cyc = -1;
   int   valid_seen = 0;
   int   hold_viol = 0;
   bit   prev_stall = 0;
   logic prev_sout, prev_last;

   // Reference stream
   logic exp_bits[$];
   logic exp_last[$];

   word_serializer #(.DATA_WIDTH(8), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .pop         (pop),
      .fifo_data   (fifo_data),
      .fifo_valid  (fifo_valid),
      .sout        (sout),
      .sout_valid  (sout_valid),
      .sout_ready  (sout_ready),
      .sout_last   (sout_last),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always begin
      @(negedge clk);
      pop_seen = pop;
      if (pop) begin
         pop_cnt++;
         pop_cyc_q.push_back(cyc);
         if (fifo_empty) pop_viol++;
      end
      @(posedge clk);
      #1;
      fifo_valid = 1'b0;
      fifo_data  = 8'($urandom);
      if (pop_seen && fifo_q.size() > 0) begin
         pend_word  = fifo_q.pop_front();
         pend_delay = no_respond ? -1 : int'($urandom_range(resp_delay_max, 0));
      end
      if (pend_delay == 0) begin
         fifo_valid = 1'b1;
         fifo_data  = pend_word;
         pend_delay = -1;
      end else if (pend_delay > 0) begin
         pend_delay--;
      end
      fifo_empty = (fifo_q.size() == 0);
      if (prev_empty && !fifo_empty) empty_fall_cyc = cyc;
      prev_empty = fifo_empty;
   end

   always @(negedge clk) begin
      if (sout_valid && sout_ready) begin
         rx_bits.push_back(sout);
         rx_last.push_back(sout_last);
         rx_cyc.push_back(cyc);
      end
      if (prev_stall && !rst && (sout !== prev_sout || sout_valid !== 1'b1 || sout_last !== prev_last))
         hold_viol++;
      prev_stall = sout_valid && !sout_ready && !rst;
      prev_sout  = sout;
      prev_last  = sout_last;
      if (sout_valid) begin
         valid_seen++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame = data bits LSB first, then (with parity) the XOR of the word.
   function automatic void model_frame(input logic [7:0] w);
      logic [8:0] ext;
      ext = {^w, w};
      for (int i = 0; i < FRAME; i++) begin
         exp_bits.push_back(ext[i]);
         exp_last.push_back(i == FRAME - 1);
      end
   endfunction

   task automatic clear_rx();
      rx_bits.delete();
      rx_last.delete();
      rx_cyc.delete();
      exp_bits.delete();
      exp_last.delete();
      pop_cyc_q.delete();
      first_valid_cyc = -1;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_bits.size() < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      total_cnt++;
      if ({pop, sout, sout_valid, sout_last} !== 4'b0)
         $display("FAIL reset_outputs: got %b expected 0000", {pop, sout, sout_valid, sout_last});
      else pass_cnt++;
      total_cnt++;
      if (timeout_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", timeout_err);
      else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_empty_idle();
      int p0, v0;
      p0 = pop_cnt;
      v0 = valid_seen;
      repeat (100) tick();
      total_cnt++;
      if (pop_cnt !== p0) $display("FAIL empty_pop: got %0d pops expected %0d", pop_cnt, p0);
      else pass_cnt++;
      total_cnt++;
      if (valid_seen !== v0) $display("FAIL empty_valid: got %0d expected %0d", valid_seen, v0);
      else pass_cnt++;
   endtask

   task automatic test_single_a5();
      logic ref_seq[8];
      int   p0, bad;
      ref_seq = '{1, 0, 1, 0, 0, 1, 0, 1};
      clear_rx();
      p0 = pop_cnt;
      sout_ready = 1'b1;
      model_frame(8'hA5);
      fifo_q.push_back(8'hA5);
      wait_rx(FRAME, 40);
      repeat (5) tick();
      total_cnt++;
      if (rx_bits.size() !== FRAME) $display("FAIL a5_count: got %0d expected %0d", rx_bits.size(), FRAME);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < 8 && i < rx_bits.size(); i++) if (rx_bits[i] !== ref_seq[i] && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL a5_sequence: bit %0d got %b expected %b", bad, rx_bits[bad], ref_seq[bad]);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < FRAME && i < rx_bits.size(); i++)
         if ((rx_bits[i] !== exp_bits[i] || rx_last[i] !== exp_last[i]) && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL a5_frame: idx %0d got bit/last %b%b expected %b%b",
                             bad, rx_bits[bad], rx_last[bad], exp_bits[bad], exp_last[bad]);
      else pass_cnt++;
      total_cnt++;
      if (pop_cnt - p0 !== 1) $display("FAIL a5_pops: got %0d expected 1", pop_cnt - p0);
      else pass_cnt++;
      total_cnt++;
      if (first_valid_cyc - empty_fall_cyc !== 3)
         $display("FAIL a5_latency: got %0d cycles expected 3", first_valid_cyc - empty_fall_cyc);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int bad;
      clear_rx();
      sout_ready = 1'b1;
      model_frame(8'h01);
      model_frame(8'hFF);
      fifo_q.push_back(8'h01);
      fifo_q.push_back(8'hFF);
      wait_rx(2 * FRAME, 80);
      repeat (5) tick();
      total_cnt++;
      if (rx_bits.size() !== 2 * FRAME) $display("FAIL b2b_count: got %0d expected %0d", rx_bits.size(), 2 * FRAME);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < exp_bits.size() && i < rx_bits.size(); i++)
         if ((rx_bits[i] !== exp_bits[i] || rx_last[i] !== exp_last[i]) && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL b2b_stream: idx %0d got bit/last %b%b expected %b%b",
                             bad, rx_bits[bad], rx_last[bad], exp_bits[bad], exp_last[bad]);
      else pass_cnt++;
      if (rx_bits.size() == 2 * FRAME && pop_cyc_q.size() == 2) begin
         total_cnt++;
         if (pop_cyc_q[1] !== rx_cyc[FRAME-1] + 1)
            $display("FAIL b2b_pop_cycle: got %0d expected %0d", pop_cyc_q[1], rx_cyc[FRAME-1] + 1);
         else pass_cnt++;
         total_cnt++;
         if (rx_cyc[FRAME] - rx_cyc[FRAME-1] !== 3)
            $display("FAIL b2b_gap: got %0d expected 3", rx_cyc[FRAME] - rx_cyc[FRAME-1]);
         else pass_cnt++;
         bad = -1;
         for (int i = 1; i < 2 * FRAME; i++)
            if (i != FRAME && rx_cyc[i] != rx_cyc[i-1] + 1 && bad < 0) bad = i;
         total_cnt++;
         if (bad >= 0) $display("FAIL b2b_contiguous: gap before bit %0d got %0d expected 1",
                                bad, rx_cyc[bad] - rx_cyc[bad-1]);
         else pass_cnt++;
      end else begin
         total_cnt++;
         $display("FAIL b2b_pops: got %0d pops, %0d bits expected 2 pops, %0d bits",
                  pop_cyc_q.size(), rx_bits.size(), 2 * FRAME);
      end
   endtask

   task automatic test_ready_toggle();
      int h0, bad;
      clear_rx();
      h0 = hold_viol;
      sout_ready = 1'b1;
      model_frame(8'h3C);
      fifo_q.push_back(8'h3C);
      for (int i = 0; i < 80 && rx_bits.size() < FRAME; i++) begin
         tick();
         sout_ready = ~sout_ready;
      end
      sout_ready = 1'b1;
      repeat (6) tick();
      total_cnt++;
      if (rx_bits.size() !== FRAME) $display("FAIL toggle_count: got %0d expected %0d", rx_bits.size(), FRAME);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < FRAME && i < rx_bits.size(); i++)
         if ((rx_bits[i] !== exp_bits[i] || rx_last[i] !== exp_last[i]) && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL toggle_stream: idx %0d got bit/last %b%b expected %b%b",
                             bad, rx_bits[bad], rx_last[bad], exp_bits[bad], exp_last[bad]);
      else pass_cnt++;
      total_cnt++;
      if (hold_viol !== h0) $display("FAIL toggle_hold: got %0d violations expected %0d", hold_viol, h0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int   n_words, pushed, h0, bad;
      logic [7:0] w;
      clear_rx();
      h0 = hold_viol;
      n_words = 20;
      pushed = 0;
      resp_delay_max = 3;
      for (int i = 0; i < 3000 && rx_bits.size() < n_words * FRAME; i++) begin
         tick();
         sout_ready = ($urandom_range(9, 0) < 7);
         if (pushed < n_words && $urandom_range(3, 0) == 0) begin
            w = 8'($urandom);
            model_frame(w);
            fifo_q.push_back(w);
            pushed++;
         end
      end
      sout_ready = 1'b1;
      resp_delay_max = 0;
      repeat (6) tick();
      total_cnt++;
      if (rx_bits.size() !== n_words * FRAME)
         $display("FAIL rand_count: got %0d expected %0d", rx_bits.size(), n_words * FRAME);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < exp_bits.size() && i < rx_bits.size(); i++)
         if ((rx_bits[i] !== exp_bits[i] || rx_last[i] !== exp_last[i]) && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL rand_stream: idx %0d got bit/last %b%b expected %b%b",
                             bad, rx_bits[bad], rx_last[bad], exp_bits[bad], exp_last[bad]);
      else pass_cnt++;
      total_cnt++;
      if (hold_viol !== h0) $display("FAIL rand_hold: got %0d violations expected %0d", hold_viol, h0);
      else pass_cnt++;
      total_cnt++;
      if (pop_viol !== 0) $display("FAIL rand_pop_empty: got %0d pops while empty expected 0", pop_viol);
      else pass_cnt++;
      total_cnt++;
      if (timeout_err !== 1'b0) $display("FAIL rand_err: got %b expected 0", timeout_err);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int cp, p0, v0;
      clear_rx();
      no_respond = 1;
      fifo_q.push_back(8'h55);
      for (int i = 0; i < 20 && pop_cyc_q.size() == 0; i++) tick();
      if (pop_cyc_q.size() == 0) begin
         total_cnt++;
         $display("FAIL timeout_pop: got 0 pops expected 1");
      end else begin
         cp = pop_cyc_q[0];
         do @(negedge clk); while (cyc < cp + 15);
         total_cnt++;
         if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b expected 0", timeout_err);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (timeout_err !== 1'b1) $display("FAIL timeout_set: got %b expected 1", timeout_err);
         else pass_cnt++;
         p0 = pop_cnt;
         v0 = valid_seen;
         repeat (20) tick();
         total_cnt++;
         if (pop_cnt !== p0 || valid_seen !== v0 || timeout_err !== 1'b1)
            $display("FAIL timeout_idle: got pops %0d valid %0d err %b expected 0 0 1",
                     pop_cnt - p0, valid_seen - v0, timeout_err);
         else pass_cnt++;
      end
      no_respond = 0;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] w1, w2;
      int bad;
      clear_rx();
      sout_ready = 1'b1;
      w1 = 8'($urandom);
      w2 = 8'($urandom);
      fifo_q.push_back(w1);
      fifo_q.push_back(w2);
      for (int i = 0; i < 40 && !(rx_bits.size() >= 3 && sout_valid); i++) tick();
      rst = 1'b1;
      #1;
      total_cnt++;
      if ({pop, sout, sout_valid, sout_last, timeout_err} !== 5'b0)
         $display("FAIL midrst_outputs: got %b expected 00000", {pop, sout, sout_valid, sout_last, timeout_err});
      else pass_cnt++;
      tick();
      rst = 1'b0;
      clear_rx();
      model_frame(w2);
      wait_rx(FRAME, 40);
      repeat (8) tick();
      total_cnt++;
      if (rx_bits.size() !== FRAME) $display("FAIL midrst_count: got %0d expected %0d", rx_bits.size(), FRAME);
      else pass_cnt++;
      bad = -1;
      for (int i = 0; i < FRAME && i < rx_bits.size(); i++)
         if ((rx_bits[i] !== exp_bits[i] || rx_last[i] !== exp_last[i]) && bad < 0) bad = i;
      total_cnt++;
      if (bad >= 0) $display("FAIL midrst_stream: idx %0d got bit/last %b%b expected %b%b",
                             bad, rx_bits[bad], rx_last[bad], exp_bits[bad], exp_last[bad]);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_empty_idle();
      test_single_a5();
      test_back_to_back();
      test_ready_toggle();
      test_random();
      test_timeout();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
